// File: rtl/stdout_arbiter.sv
// Round-robin arbiter that drains NREQ per-requester character FIFOs into one valid/ready sink.
// Define STDOUT_ARB_LINE_LOCK_EN to hold the grant until a newline (or LINE_TIMEOUT idle cycles).
module stdout_arbiter #(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned DATAW        = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned LINE_TIMEOUT = 64
) (
    input  logic                                       clk,
    input  logic                                       rstx,
    input  logic                                       glock,
    input  logic [NREQ*DATAW-1:0]                      req_data,
    input  logic [NREQ-1:0]                            req_load,
    output logic                                       glockreq,
    output logic [DATAW-1:0]                           out_data,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] out_src,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [NREQ-1:0]                            ovf
);

    localparam int unsigned SrcW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [SrcW-1:0] src_t;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    if (NREQ < 2 || NREQ > 8 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LINE_TIMEOUT < 1) begin : g_param_check
        $error("stdout_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        StIdle,
        StSend
`ifdef STDOUT_ARB_LINE_LOCK_EN
        , StLineWait
`endif
    } state_e;

    state_e            state_q, state_d;
    src_t              rr_q, rr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATAW-1:0]  out_data_q, out_data_d;
    src_t              out_src_q, out_src_d;
    logic              glockreq_q, glockreq_d;
    logic [NREQ-1:0]   ovf_q, ovf_d;
    cnt_t              cnt_q [NREQ];
    cnt_t              cnt_d [NREQ];
    ptr_t              wr_ptr_q [NREQ];
    ptr_t              wr_ptr_d [NREQ];
    ptr_t              rd_ptr_q [NREQ];
    ptr_t              rd_ptr_d [NREQ];
    logic [DATAW-1:0]  mem_q [NREQ][FIFO_DEPTH];

    logic [NREQ-1:0]   nonempty, full, push, pop_vec;
    logic              pop_en;
    src_t              pop_idx;
    logic              handshake;
    logic              found_idle, found_next;
    src_t              pick_idle, pick_next;

    function automatic src_t src_inc(input src_t g);
        if (g == src_t'(NREQ - 1)) begin
            return '0;
        end
        return g + src_t'(1);
    endfunction

    // First non-empty FIFO at or after start, wrapping; MSB of the result is the found flag.
    function automatic logic [SrcW:0] rr_pick(input src_t start, input logic [NREQ-1:0] ne);
        logic found;
        src_t idx;
        src_t cand;
        found = 1'b0;
        idx   = '0;
        cand  = start;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && ne[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
            cand = src_inc(cand);
        end
        return {found, idx};
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            full[i]     = (cnt_q[i] == cnt_t'(FIFO_DEPTH));
        end
    end

    assign handshake                = out_valid_q & out_ready;
    assign {found_idle, pick_idle}  = rr_pick(rr_q, nonempty);
    assign {found_next, pick_next}  = rr_pick(src_inc(out_src_q), nonempty);

`ifdef STDOUT_ARB_LINE_LOCK_EN
    localparam int unsigned NlW   = (DATAW < 8) ? DATAW : 8;
    localparam int unsigned IdleW = $clog2(LINE_TIMEOUT + 1);

    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             is_nl;

    assign is_nl = (out_data_q[NlW-1:0] == NlW'(8'h0A));
`endif

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        pop_en      = 1'b0;
        pop_idx     = '0;
`ifdef STDOUT_ARB_LINE_LOCK_EN
        idle_cnt_d  = idle_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (found_idle) begin
                    pop_en  = 1'b1;
                    pop_idx = pick_idle;
                    state_d = StSend;
                end
            end
`ifdef STDOUT_ARB_LINE_LOCK_EN
            // out_src_q doubles as the held line grant while a line is open.
            StSend: begin
                if (handshake) begin
                    if (is_nl) begin
                        rr_d = src_inc(out_src_q);
                        if (found_next) begin
                            pop_en  = 1'b1;
                            pop_idx = pick_next;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = StIdle;
                        end
                    end else if (nonempty[out_src_q]) begin
                        pop_en  = 1'b1;
                        pop_idx = out_src_q;
                    end else begin
                        out_valid_d = 1'b0;
                        idle_cnt_d  = '0;
                        state_d     = StLineWait;
                    end
                end
            end
            StLineWait: begin
                if (nonempty[out_src_q]) begin
                    pop_en     = 1'b1;
                    pop_idx    = out_src_q;
                    idle_cnt_d = '0;
                    state_d    = StSend;
                end else if (idle_cnt_q == IdleW'(LINE_TIMEOUT - 1)) begin
                    rr_d       = src_inc(out_src_q);
                    idle_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    idle_cnt_d = idle_cnt_q + IdleW'(1);
                end
            end
`else
            StSend: begin
                if (handshake) begin
                    rr_d = src_inc(out_src_q);
                    if (found_next) begin
                        pop_en  = 1'b1;
                        pop_idx = pick_next;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
        if (pop_en) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[pop_idx][rd_ptr_q[pop_idx]];
            out_src_d   = pop_idx;
        end
    end

    // A same-edge pop frees a slot, so a load into a full FIFO still lands in that case.
    always_comb begin
        ovf_d      = ovf_q;
        glockreq_d = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pop_vec[i]  = pop_en && (pop_idx == src_t'(i));
            push[i]     = req_load[i] && !glock && (!full[i] || pop_vec[i]);
            cnt_d[i]    = cnt_q[i] + cnt_t'(push[i]) - cnt_t'(pop_vec[i]);
            wr_ptr_d[i] = wr_ptr_q[i] + ptr_t'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + ptr_t'(pop_vec[i]);
            if (req_load[i] && !glock && full[i] && !pop_vec[i]) begin
                ovf_d[i] = 1'b1;
            end
            if (cnt_d[i] == cnt_t'(FIFO_DEPTH)) begin
                glockreq_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstx) begin
            state_q     <= StIdle;
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            glockreq_q  <= 1'b0;
            ovf_q       <= '0;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i]    <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
`ifdef STDOUT_ARB_LINE_LOCK_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            glockreq_q  <= glockreq_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
`ifdef STDOUT_ARB_LINE_LOCK_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= req_data[i*DATAW +: DATAW];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign glockreq  = glockreq_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_stdout_arbiter.sv
// Directed self-checking bench for stdout_arbiter (NREQ=2, DATAW=8, FIFO_DEPTH=4).
module tb_stdout_arbiter;

    logic        clk = 1'b0;
    logic        rstx;
    logic        glock;
    logic [15:0] req_data;
    logic [1:0]  req_load;
    logic        glockreq;
    logic [7:0]  out_data;
    logic [0:0]  out_src;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stdout_arbiter #(
        .NREQ        (2),
        .DATAW       (8),
        .FIFO_DEPTH  (4),
        .LINE_TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .rstx     (rstx),
        .glock    (glock),
        .req_data (req_data),
        .req_load (req_load),
        .glockreq (glockreq),
        .out_data (out_data),
        .out_src  (out_src),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ovf      (ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstx = 1'b1;
        step();
        rstx = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic s);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_src"}, 32'(out_src), 32'(s));
    endtask

    initial begin
        rstx      = 1'b1;
        glock     = 1'b0;
        req_data  = '0;
        req_load  = '0;
        out_ready = 1'b1;
        step();
        step();
        rstx = 1'b0;

        // Reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_src", 32'(out_src), 32'd0);
        check("rst_glockreq", 32'(glockreq), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // Single character latency
        req_data = 16'h0041;
        req_load = 2'b01;
        step();
        req_load = 2'b00;
        check("t1_not_yet", 32'(out_valid), 32'd0);
        step();
        expect_out("t1_out", 8'h41, 1'b0);
        step();
        check("t1_drained", 32'(out_valid), 32'd0);

        // Two requesters interleave with no bubbles
        do_reset();
        req_data = 16'h6131;
        req_load = 2'b11;
        step();
        req_data = 16'h6232;
        step();
        req_load = 2'b00;
        expect_out("t2_c0", 8'h31, 1'b0);
        step();
        expect_out("t2_c1", 8'h61, 1'b1);
        step();
        expect_out("t2_c2", 8'h32, 1'b0);
        step();
        expect_out("t2_c3", 8'h62, 1'b1);
        step();
        check("t2_drained", 32'(out_valid), 32'd0);

        // Backpressure fills FIFO 0; first char sits in the output register
        out_ready = 1'b0;
        req_load  = 2'b01;
        for (int k = 0; k < 5; k++) begin
            req_data = 16'(8'h10 + k);
            step();
            if (k == 3) check("t3_glockreq_before_full", 32'(glockreq), 32'd0);
        end
        check("t3_glockreq_full", 32'(glockreq), 32'd1);
        expect_out("t3_hold", 8'h10, 1'b0);
        req_data = 16'h0015;
        step();
        check("t3_ovf", 32'(ovf), 32'd1);
        check("t3_glockreq_still", 32'(glockreq), 32'd1);
        check("t3_hold_data", 32'(out_data), 32'h10);
        // Full FIFO plus same-edge pop: the push is accepted
        out_ready = 1'b1;
        req_data  = 16'h0016;
        step();
        req_load = 2'b00;
        expect_out("t3_d0", 8'h11, 1'b0);
        check("t3_glockreq_refill", 32'(glockreq), 32'd1);
        step();
        expect_out("t3_d1", 8'h12, 1'b0);
        check("t3_glockreq_clear", 32'(glockreq), 32'd0);
        step();
        expect_out("t3_d2", 8'h13, 1'b0);
        step();
        expect_out("t3_d3", 8'h14, 1'b0);
        step();
        expect_out("t3_d4", 8'h16, 1'b0);
        step();
        check("t3_drained", 32'(out_valid), 32'd0);
        check("t3_ovf_sticky", 32'(ovf), 32'd1);

        // glock blocks all loads
        do_reset();
        glock    = 1'b1;
        req_data = 16'h5152;
        req_load = 2'b11;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_glock_valid", 32'(out_valid), 32'd0);
        end
        glock    = 1'b0;
        req_load = 2'b00;
        step();
        step();
        check("t4_no_push", 32'(out_valid), 32'd0);
        check("t4_ovf", 32'(ovf), 32'd0);
        check("t4_glockreq", 32'(glockreq), 32'd0);

        // Reset mid-stream discards buffered characters
        out_ready = 1'b0;
        req_data  = 16'h2120;
        req_load  = 2'b11;
        step();
        req_data = 16'h0022;
        req_load = 2'b01;
        step();
        req_load = 2'b00;
        expect_out("t5_pending", 8'h20, 1'b0);
        do_reset();
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_glockreq", 32'(glockreq), 32'd0);
        check("t5_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_no_stale", 32'(out_valid), 32'd0);
        end

`ifdef STDOUT_ARB_LINE_LOCK_EN
        // Line lock: req0's line completes before req1 is served
        do_reset();
        req_data = 16'h7861;
        req_load = 2'b11;
        step();
        req_data = 16'h0062;
        req_load = 2'b01;
        step();
        expect_out("ll_a", 8'h61, 1'b0);
        req_data = 16'h000A;
        step();
        req_load = 2'b00;
        expect_out("ll_b", 8'h62, 1'b0);
        step();
        expect_out("ll_nl", 8'h0A, 1'b0);
        step();
        expect_out("ll_x", 8'h78, 1'b1);
        step();
        check("ll_wait", 32'(out_valid), 32'd0);
        for (int k = 0; k < 10; k++) step();
        // Open line on req0 with no newline; req1 must wait for the timeout
        req_data = 16'h7963;
        req_load = 2'b11;
        step();
        req_load = 2'b00;
        step();
        expect_out("ll_c", 8'h63, 1'b0);
        step();
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                step();
                n++;
            end
            expect_out("ll_timeout_y", 8'h79, 1'b1);
            check("ll_timeout_len", 32'(n >= 8), 32'd1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
